// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: sequential unsigned shift-and-add multiplier controller.
// A start/done handshake wraps a left-shifting multiplicand, a right-shifting
// multiplier, an iteration counter and an enable-gated accumulator.
// Optional build macro: MULT_EARLY_TERM_EN stops iterating as soon as no set
// multiplier bits remain, shortening latency without changing the product.
//
// state  | meaning
// S_IDLE | waiting for Start; operands are captured on the accepting edge
// S_CALC | one shift/add iteration per cycle
// S_DONE | product registered; Done pulses for this single cycle
module shift_add_mult_ctrl #(
  parameter int SIZE = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [SIZE-1:0]   A,
  input  logic [SIZE-1:0]   B,
  output logic              Busy,
  output logic              Done,
  output logic [2*SIZE-1:0] Result
);

  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [2*SIZE-1:0] mcand;
  logic [2*SIZE-1:0] acc;
  logic [2*SIZE-1:0] addend;
  logic [2*SIZE-1:0] acc_sum;
  logic [SIZE-1:0]   mplier;
  logic [CW-1:0]     count;
  logic              last_iter;
  logic              load;
  logic              step;

  // Partial-product selection and the accumulator sum (carry-out cannot occur).
  always_comb begin
    addend  = mplier[0] ? mcand : '0;
    acc_sum = acc + addend;
  end

  // Last iteration: full width reached, or optionally no multiplier bits left.
  always_comb begin
`ifdef MULT_EARLY_TERM_EN
    last_iter = (count == CW'(SIZE - 1)) || ((mplier >> 1) == '0);
`else
    last_iter = (count == CW'(SIZE - 1));
`endif
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode plus datapath enables and handshake outputs.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          load       = 1'b1;
          state_next = S_CALC;
        end
      end
      S_CALC: begin
        Busy = 1'b1;
        step = 1'b1;
        if (last_iter) state_next = S_DONE;
      end
      S_DONE: begin
        Busy       = 1'b1;
        Done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers: operand capture, iteration, and result latch on exit.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      Result <= '0;
    end else if (load) begin
      mcand  <= {{SIZE{1'b0}}, A};
      mplier <= B;
      acc    <= '0;
      count  <= '0;
    end else if (step) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (last_iter) Result <= acc_sum;
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl (SIZE=8). A behavioural model
// tracks expected Busy/Done/Result every cycle; directed operations pin the
// model with hand-computed products and latencies; random traffic follows.
module tb_shift_add_mult_ctrl;

  localparam int SIZE = 8;
`ifdef MULT_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              Start = 1'b0;
  logic [SIZE-1:0]   A = '0;
  logic [SIZE-1:0]   B = '0;
  logic              Busy;
  logic              Done;
  logic [2*SIZE-1:0] Result;

  int total = 0;
  int bad   = 0;

  shift_add_mult_ctrl #(.SIZE(SIZE)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .Done  (Done),
    .Result(Result)
  );

  always #5 Clock = ~Clock;

  function automatic void check(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Number of CALC cycles the operation with multiplier b must take.
  function automatic int calc_len(logic [SIZE-1:0] b);
    int n;
    if (!ET) return SIZE;
    n = 1;
    for (int i = 0; i < SIZE; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  // Behavioural model: phase 0 idle, 1 computing (m_left cycles to go), 2 done.
  int     m_phase   = 0;
  int     m_left    = 0;
  longint m_pending = 0;
  longint m_result  = 0;
  bit     m_valid   = 1'b0;

  always @(posedge Clock) begin
    if (Reset) begin
      m_phase  <= 0;
      m_result <= 0;
      m_valid  <= 1'b1;
    end else begin
      case (m_phase)
        0: if (Start) begin
             m_phase   <= 1;
             m_left    <= calc_len(B);
             m_pending <= longint'(A) * longint'(B);
           end
        1: if (m_left == 1) begin
             m_phase  <= 2;
             m_result <= m_pending;
           end else begin
             m_left <= m_left - 1;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge Clock) begin
    if (m_valid) begin
      check("busy",   Busy,   longint'(m_phase != 0));
      check("done",   Done,   longint'(m_phase == 2));
      check("result", Result, m_result);
    end
  end

  // One operation: pulse Start, count cycles (cycle 1 = first after the
  // accepting edge) until Done, then pin latency and product.
  task automatic run_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input longint exp_res, input int exp_cyc, input string name);
    int c;
    bit seen;
    @(negedge Clock);
    Start = 1'b1; A = a; B = b;
    @(negedge Clock);
    Start = 1'b0;
    c = 1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (Done) seen = 1'b1;
      else begin
        @(negedge Clock);
        c++;
      end
    end
    check({name, "_seen"}, seen, 1);
    check({name, "_cycle"}, c, exp_cyc);
    check({name, "_res"}, Result, exp_res);
    @(negedge Clock);
    check({name, "_hold"}, Result, exp_res);
  endtask

  initial begin
    int c;
    int g;
    bit seen;

    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_res",  Result, 0);

    run_op(8'd13,  8'd11,  143,   ET ? 5 : 9, "m13x11");
    run_op(8'd255, 8'd255, 65025, 9,          "m255x255");
    run_op(8'd0,   8'd200, 0,     ET ? 9 : 9, "m0x200");
    run_op(8'd200, 8'd0,   0,     ET ? 2 : 9, "m200x0");
    run_op(8'd100, 8'h03,  300,   ET ? 3 : 9, "m100x3");
    run_op(8'd2,   8'h80,  256,   9,          "m2x128");

    // Start held high; operands changed mid-calculation must not matter.
    @(negedge Clock);
    Start = 1'b1; A = 8'd13; B = 8'd11;
    c = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clock);
      c++;
      if (c == 3) begin A = 8'd7; B = 8'd7; end
      if (Done) seen = 1'b1;
    end
    check("held_first_seen", seen, 1);
    check("held_first_cycle", c, ET ? 5 : 9);
    check("held_first_res", Result, 143);
    g = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clock);
      g++;
      if (Done) seen = 1'b1;
    end
    Start = 1'b0;
    check("held_second_seen", seen, 1);
    check("held_gap", g, ET ? 5 : 10);
    check("held_second_res", Result, 49);

    // Reset in the fourth CALC cycle aborts the operation.
    @(negedge Clock);
    Start = 1'b1; A = 8'd50; B = 8'd60;
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_res",  Result, 0);
    repeat (12) begin
      @(negedge Clock);
      check("abort_nodone", Done, 0);
    end
    run_op(8'd6, 8'd9, 54, ET ? 5 : 9, "m6x9");

    // Reset and Start together: Start must not be captured.
    @(negedge Clock);
    Reset = 1'b1; Start = 1'b1; A = 8'd3; B = 8'd3;
    @(negedge Clock);
    Reset = 1'b0; Start = 1'b0;
    check("rst_start_busy", Busy, 0);
    @(negedge Clock);
    check("rst_start_busy2", Busy, 0);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clock);
      Start = ($urandom_range(0, 3) == 0);
      A = SIZE'($urandom);
      case ($urandom_range(0, 3))
        0:       B = SIZE'($urandom_range(0, 3));
        1:       B = SIZE'(1) << $urandom_range(0, SIZE - 1);
        default: B = SIZE'($urandom);
      endcase
      Reset = ($urandom_range(0, 249) == 0);
    end
    @(negedge Clock);
    Reset = 1'b0; Start = 1'b0;
    repeat (20) @(negedge Clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
